seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning the scan tick period in clk cycles; legal range is DIV >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: scan enable.
REQ-005 SHALL have port req_a, input, 1 bit: display-update request from requester A, level, held until granted.
REQ-006 SHALL have port data_a, input, 32 bits: eight nibbles from A; digit 0 = [31:28] ... digit 7 = [3:0]; stable while req_a is high.
REQ-007 SHALL have ports req_b (input, 1 bit) and data_b (input, 32 bits): requester B, with the same rules as A.
REQ-008 SHALL have port num_cfg, input, 3 bits: active digit count minus 1.
REQ-009 SHALL have ports gnt_a and gnt_b, each output, 1 bit: one-cycle grant pulses.
REQ-010 SHALL have port an, output, 8 bits: active-low digit enable, one-hot-low; 8'hFF means all digits off.
REQ-011 SHALL have port mout, output, 4 bits: nibble value for the enabled digit.

Function
REQ-012 SHALL run a prescaler from 0 to DIV-1 while en=1; tick is asserted in the cycle where the count equals DIV-1, and the count then wraps to 0.
REQ-013 SHALL hold a scan index sel (0..7), a 32-bit display buffer buf, and a latched digit count last (3 bits).
REQ-014 SHALL, on each tick edge, register mout <= buf nibble[sel] and an <= ~(8'b1 << sel).
REQ-015 SHALL, on each tick edge, set sel to sel+1 if sel < last, or to 0 otherwise.
REQ-016 SHALL define a frame boundary as a tick with sel == last, or any cycle with en=0.
REQ-017 SHALL, at a frame-boundary edge, latch last <= num_cfg every time, whether or not any request is pending.
REQ-018 SHALL, at a frame-boundary edge, grant at most one requester: A alone -> A; B alone -> B; both -> the requester not granted last (round-robin).
REQ-019 SHALL, for a granted requester X, load buf <= data_X at the boundary edge and assert gnt_X high for exactly the following cycle; gnt_a and gnt_b are never high together.
REQ-020 SHALL ignore a request arriving mid-frame until the next frame boundary.
REQ-021 SHALL display digit 0 of the newly loaded buf on the first tick after the boundary, so a frame never mixes old and new data.
REQ-022 SHALL ignore a num_cfg change mid-frame until the next frame boundary.
REQ-023 SHALL, while en=0, force an=8'hFF, sel=0 and prescaler=0 from the next edge, with mout holding its value.
REQ-024 SHALL, after en rises, produce the first tick DIV cycles later.
REQ-025 SHALL treat rst as having priority over en and over all requests.

Reset
REQ-026 SHALL, with rst=1, set the following on the next edge: prescaler=0, sel=0, last=0, buf=0, mout=0, an=8'hFF, gnt_a=0, gnt_b=0, and last-granted=B (so A wins the first tie).
REQ-027 SHALL, when rst is asserted mid-frame, abort the frame; pending requests are not granted until a boundary after rst deasserts.

Structure
REQ-028 SHALL place the constants DIGITS=8, NIBBLE_W=4 and AN_OFF=8'hFF in the shared package seg_pkg.
REQ-029 SHALL implement the prescaler as the sub-module seg_tick_gen, with ports clk, rst, en, tick and parameter DIV.
REQ-030 SHALL keep the arbiter, buffer and scan logic inside seg_scan_ctrl.

Verification (bench uses DIV=4)
REQ-031 SHALL cover: rst held 3 cycles -> an=FF, mout=0, gnt=0; release with en=1 and no requests -> every 4th cycle mout=0, an=FE.
REQ-032 SHALL cover: req_a with data_a=32'h12345678 and num_cfg=7 -> gnt_a pulse one cycle after the boundary; on subsequent ticks mout=1..8 with an=FE, FD, FB, F7, EF, DF, BF, 7F, then repeating.
REQ-033 SHALL cover: req_a and req_b both held from reset -> gnt_a at the 1st boundary, gnt_b at the 2nd, gnt_a at the 3rd (alternating); buf tracks the granted data.
REQ-034 SHALL cover: num_cfg=2 -> an cycles FE, FD, FB; num_cfg changed to 0 mid-frame -> the current frame finishes its 3 digits, then only FE is shown.
REQ-035 SHALL cover: en dropped mid-frame -> an=FF next cycle; req_b (data 32'hABCD0000) granted the next cycle; en raised -> first tick 4 cycles later shows mout=A, an=FE.
REQ-036 SHALL cover: rst pulsed mid-frame with req_a pending -> reset values next cycle; gnt_a not asserted until the first boundary after rst deasserts.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and digit helpers for the segment scan controller
package seg_pkg;
  localparam int DIGITS = 8;
  localparam int NIBBLE_W = 4;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam int SEL_W = $clog2(DIGITS);
  // Digit 0 lives in the most significant nibble.
  function automatic logic [NIBBLE_W-1:0] nibble(input logic [DIGITS*NIBBLE_W-1:0] b, input logic [SEL_W-1:0] s);
    return b[(DIGITS-1-int'(s))*NIBBLE_W +: NIBBLE_W];
  endfunction
  function automatic logic [DIGITS-1:0] an_of(input logic [SEL_W-1:0] s);
    return ~(DIGITS'(1) << s);
  endfunction
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: scan prescaler, one tick every DIV enabled cycles
module seg_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && (cnt_q == W'(DIV-1));
  always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 8-digit scan with frame-aligned round-robin buffer updates
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  input  logic [2:0]  num_cfg,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  an,
  output logic [3:0]  mout
);
  logic tick, bnd, ga, gb;
  logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d;
  logic [31:0] buf_q, buf_d;
  logic [NIBBLE_W-1:0] mout_q, mout_d;
  logic [7:0] an_q, an_d;
  logic gnt_a_q, gnt_b_q, lastb_q, lastb_d;
  seg_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .en(en), .tick(tick));
  // A request still high during its own grant pulse is already served.
  always_comb begin
    bnd = !en || (tick && sel_q == last_q);
    ga = bnd && req_a && !gnt_a_q && (!(req_b && !gnt_b_q) || lastb_q);
    gb = bnd && req_b && !gnt_b_q && !ga;
    sel_d = !en ? '0 : tick ? ((sel_q < last_q) ? sel_q + 1'b1 : '0) : sel_q;
    an_d = !en ? AN_OFF : tick ? an_of(sel_q) : an_q;
    mout_d = tick ? nibble(buf_q, sel_q) : mout_q;
    buf_d = ga ? data_a : gb ? data_b : buf_q;
    last_d = bnd ? num_cfg : last_q;
    lastb_d = ga ? 1'b0 : gb ? 1'b1 : lastb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      last_q <= '0;
      buf_q <= '0;
      mout_q <= '0;
      an_q <= AN_OFF;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      lastb_q <= 1'b1;
    end else begin
      sel_q <= sel_d;
      last_q <= last_d;
      buf_q <= buf_d;
      mout_q <= mout_d;
      an_q <= an_d;
      gnt_a_q <= ga;
      gnt_b_q <= gb;
      lastb_q <= lastb_d;
    end
  end
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign an = an_q;
  assign mout = mout_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenarios plus random traffic against a cycle model of the scan rules
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  logic clk = 0, rst = 1, en = 0, req_a = 0, req_b = 0;
  logic [31:0] data_a = 0, data_b = 0;
  logic [2:0] num_cfg = 0;
  logic gnt_a, gnt_b;
  logic [7:0] an;
  logic [3:0] mout;
  int n_chk = 0, n_pass = 0;
  int m_cnt = 0, m_sel = 0, m_last = 0;
  logic [31:0] m_buf = 0;
  logic [3:0] m_mout = 0;
  logic [7:0] m_an = 8'hFF;
  logic m_ga = 0, m_gb = 0, m_lastb = 1, m_tick = 0;
  bit auto_drop = 1;
  logic [7:0] seen [6];
  logic [7:0] exp_an8 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] exp_34 [6] = '{8'hFE, 8'hFE, 8'hFD, 8'hFB, 8'hFE, 8'hFE};

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .req_a(req_a), .data_a(data_a), .req_b(req_b),
    .data_b(data_b), .num_cfg(num_cfg), .gnt_a(gnt_a), .gnt_b(gnt_b), .an(an), .mout(mout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Applies the scan rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit bnd;
    if (rst) begin
      m_cnt = 0; m_sel = 0; m_last = 0; m_buf = 0; m_mout = 0; m_an = 8'hFF;
      m_ga = 0; m_gb = 0; m_lastb = 1; m_tick = 0;
      return;
    end
    m_tick = en && (m_cnt == DIV - 1);
    bnd = !en || (m_tick && m_sel == m_last);
    m_cnt = en ? (m_cnt + 1) % DIV : 0;
    if (m_tick) begin
      m_mout = m_buf[28 - 4*m_sel +: 4];
      m_an = 8'hFF ^ (8'h01 << m_sel);
      m_sel = (m_sel < m_last) ? m_sel + 1 : 0;
    end
    if (!en) begin
      m_an = 8'hFF;
      m_sel = 0;
    end
    m_ga = bnd && req_a && (!req_b || m_lastb);
    m_gb = bnd && req_b && !m_ga;
    if (m_ga) begin m_buf = data_a; m_lastb = 0; end
    if (m_gb) begin m_buf = data_b; m_lastb = 1; end
    if (bnd) m_last = num_cfg;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mout", mout, m_mout);
    chk("an", an, m_an);
    chk("gnt_a", gnt_a, m_ga);
    chk("gnt_b", gnt_b, m_gb);
    if (auto_drop && gnt_a) req_a = 0;
    if (auto_drop && gnt_b) req_b = 0;
  endtask

  initial begin
    int k, t, g;
    logic [2:0] seq;
    rst = 1;
    repeat (3) step();
    chk("rst_an", an, 8'hFF);
    chk("rst_mout", mout, 0);
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    rst = 0; en = 1;
    repeat (3) step();
    chk("idle_pre_an", an, 8'hFF);
    repeat (9) step();
    chk("idle_an", an, 8'hFE);
    chk("idle_mout", mout, 0);
    // Full 8-digit frame of a single update
    data_a = 32'h12345678; num_cfg = 7; req_a = 1;
    k = 0;
    while (!gnt_a && k < 12) begin step(); k++; end
    chk("s32_gnt", gnt_a, 1);
    t = 0; k = 0;
    while (t < 16 && k < 100) begin
      step(); k++;
      if (m_tick) begin
        chk("s32_mout", mout, (t % 8) + 1);
        chk("s32_an", an, exp_an8[t % 8]);
        t++;
      end
    end
    chk("s32_ticks", t, 16);
    // Both requesters held: grants alternate starting with A
    rst = 1; auto_drop = 0; req_a = 1; req_b = 1;
    data_a = 32'hA0000000; data_b = 32'hB0000000; num_cfg = 0;
    step();
    rst = 0;
    g = 0; k = 0; seq = 0;
    while (g < 3 && k < 60) begin
      step(); k++;
      if (gnt_a) begin seq[g] = 0; g++; end
      else if (gnt_b) begin seq[g] = 1; g++; end
    end
    chk("s33_order", seq, 3'b010);
    chk("s33_count", g, 3);
    req_a = 0; req_b = 0; auto_drop = 1;
    step();
    // Digit count change only takes effect at the frame boundary
    rst = 1; num_cfg = 2;
    step();
    rst = 0;
    t = 0; k = 0;
    while (t < 6 && k < 100) begin
      step(); k++;
      if (m_tick) begin
        seen[t] = an;
        if (t == 2) num_cfg = 0;
        t++;
      end
    end
    for (int i = 0; i < 6; i++) chk("s34_an", seen[i], exp_34[i]);
    // Enable dropped mid-frame, update granted while idle
    num_cfg = 3;
    repeat (10) step();
    en = 0; req_b = 1; data_b = 32'hABCD0000;
    step();
    chk("s35_off", an, 8'hFF);
    chk("s35_gnt_b", gnt_b, 1);
    num_cfg = 0;
    repeat (2) step();
    en = 1;
    repeat (3) step();
    chk("s35_pre", an, 8'hFF);
    step();
    chk("s35_mout", mout, 4'hA);
    chk("s35_an", an, 8'hFE);
    // Reset mid-frame with A pending
    num_cfg = 3;
    repeat (9) step();
    req_a = 1; data_a = 32'h5A5A5A5A; rst = 1;
    step();
    chk("s36_an", an, 8'hFF);
    chk("s36_mout", mout, 0);
    chk("s36_gnt0", gnt_a, 0);
    rst = 0;
    repeat (3) begin step(); chk("s36_hold", gnt_a, 0); end
    step();
    chk("s36_gnt", gnt_a, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      en = ($urandom_range(0, 9) != 0);
      if (!req_a && !gnt_a && $urandom_range(0, 7) == 0) begin req_a = 1; data_a = $urandom; end
      if (!req_b && !gnt_b && $urandom_range(0, 7) == 0) begin req_b = 1; data_b = $urandom; end
      if ($urandom_range(0, 15) == 0) num_cfg = 3'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
